// File: rtl/updown_ctrl_pkg.sv
// Shared opcode and FSM state definitions for the command-driven up/down counter.
package updown_ctrl_pkg;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_UP   = 2'b01;
   localparam logic [1:0] OP_DOWN = 2'b10;
   localparam logic [1:0] OP_LOAD = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/updown_core.sv
// WIDTH-bit wrapping counter datapath with a registered wrap pulse.
module updown_core #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             dir,      // 0 = up, 1 = down
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;

   // Load takes priority over stepping and never reports a wrap.
   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (load) begin
         count_d = load_val;
      end else if (en) begin
         if (dir) begin
            count_d = count_q - WIDTH'(1);
            wrap_d  = (count_q == '0);
         end else begin
            count_d = count_q + WIDTH'(1);
            wrap_d  = (count_q == '1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   assign count = count_q;
   assign wrap  = wrap_q;

endmodule

// File: rtl/updown_ctrl.sv
// Command sequencer: accepts NOP/UP/DOWN/LOAD and steps the counter one position per cycle.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready; the master holds it otherwise.
module updown_ctrl
   import updown_ctrl_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int STEP_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [STEP_W-1:0] cmd_arg,
   input  logic              pause,
   output logic [WIDTH-1:0]  count,
   output logic              busy,
   output logic              done,
   output logic              wrap,
   output state_t            dbg_state
);

   state_t            state_q, state_d;
   logic [STEP_W-1:0] rem_q, rem_d;
   logic              dir_q, dir_d;
   logic              done_q, done_d;
   logic              core_en, core_load;
   logic              accept;

   assign cmd_ready = (state_q == ST_IDLE) && !reset;
   assign accept    = cmd_valid && cmd_ready;

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      dir_d     = dir_q;
      done_d    = 1'b0;
      core_en   = 1'b0;
      core_load = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (cmd_op)
                  OP_LOAD: begin
                     core_load = 1'b1;
                     done_d    = 1'b1;
                  end
                  OP_UP, OP_DOWN: begin
                     if (cmd_arg == '0) begin
                        done_d = 1'b1;
                     end else begin
                        dir_d   = (cmd_op == OP_DOWN);
                        rem_d   = cmd_arg;
                        state_d = ST_RUN;
                     end
                  end
                  default: done_d = 1'b1;
               endcase
            end
         end
         ST_RUN: begin
            // A paused cycle holds both count and remaining steps.
            if (!pause) begin
               core_en = 1'b1;
               rem_d   = rem_q - STEP_W'(1);
               if (rem_q == STEP_W'(1)) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         dir_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         dir_q   <= dir_d;
         done_q  <= done_d;
      end
   end

   updown_core #(.WIDTH(WIDTH)) u_core (
      .clk      (clk),
      .reset    (reset),
      .en       (core_en),
      .dir      (dir_q),
      .load     (core_load),
      .load_val (cmd_arg[WIDTH-1:0]),
      .count    (count),
      .wrap     (wrap)
   );

   assign busy      = (state_q == ST_RUN);
   assign done      = done_q;
   assign dbg_state = state_q;

endmodule

// File: doc/updown_ctrl.md
# updown_ctrl

Command-driven sequencer for a WIDTH-bit wrapping up/down counter. Accepts LOAD, UP-by-N, DOWN-by-N and NOP commands over a valid/ready handshake. Steps the counter one position per cycle until the command completes, and reports completion and wrap events. It sits between a control master (test sequencer or register block) and the counter datapath, and replaces free-running up/down counting with bounded, acknowledged moves.

## Interface
Parameters:
- WIDTH, 4, counter width; count range 0 .. 2^WIDTH-1
- STEP_W, 8, width of the step-count argument; max steps per command 2^STEP_W-1

Ports:
- clk  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-high; clears all state on the edge where sampled high
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  2  opcode: 00 NOP, 01 UP, 10 DOWN, 11 LOAD
- cmd_arg  in  STEP_W  step count for UP/DOWN; arg[WIDTH-1:0] is the load value for LOAD
- pause  in  1  freezes stepping while RUN; ignored in IDLE
- count  out  WIDTH  current counter value (registered)
- busy  out  1  high while a multi-step command executes
- done  out  1  one-cycle pulse on command completion
- wrap  out  1  one-cycle pulse when a step wraps

## Operation
- FSM states:
  - IDLE: cmd_ready = 1 unless reset is high.
  - RUN: cmd_ready = 0, busy = 1.
- Accept occurs on an edge where cmd_valid && cmd_ready. Commands presented while not ready are held by the master and are not lost or reordered.
- NOP, or UP/DOWN with arg = 0: count unchanged. done pulses in the cycle after the accept edge. State stays IDLE.
- LOAD: count <= arg[WIDTH-1:0] on the accept edge. done pulses in the following cycle. State stays IDLE. wrap is not asserted.
- UP/DOWN with arg = N > 0:
  - Latch the direction and set remaining <= N. Go to RUN.
  - Each RUN edge with pause = 0: count ±1 modulo 2^WIDTH, remaining - 1.
  - On the step where remaining = 1: return to IDLE and assert done for the next cycle.
- Each RUN edge with pause = 1: count and remaining are held. No done and no wrap.
- Wrap rules: UP from 2^WIDTH-1 goes to 0; DOWN from 0 goes to 2^WIDTH-1. wrap is registered with that step. Multiple wraps per command are allowed (N > 2^WIDTH).
- done and wrap may be high in the same cycle.
- Reset mid-RUN aborts the command: no done pulse, remaining discarded.

## Timing
- Reset values: count = 0, state IDLE, busy = 0, done = 0, wrap = 0. cmd_ready = 0 while reset is high and 1 from the first cycle after reset.
- Accept at edge T with N > 0 and no pause:
  - count updates at edges T+1 .. T+N.
  - busy is high in cycles after edges T .. T+N-1.
  - done is high in the cycle after edge T+N, coinciding with the final count value. cmd_ready is also 1 in that cycle.
- Each paused cycle extends all subsequent timing by one cycle.
- Throughput: N+1 cycles per stepping command; 1 cycle per LOAD/NOP, so back-to-back accepts are possible.
- No combinational path from cmd_valid or pause to any output. cmd_ready depends only on state and reset.

## Structure
- Package updown_ctrl_pkg:
  - opcode localparams OP_NOP, OP_UP, OP_DOWN, OP_LOAD
  - state encoding ST_IDLE, ST_RUN
- Sub-module updown_core: WIDTH-bit counter.
  - Inputs: en, dir, load, load_val.
  - Output: registered wrap pulse.
  - Synchronous active-high reset to 0.
- updown_ctrl holds the FSM, the remaining-step register (STEP_W bits), the done register, and the handshake.

## Test plan
- Reset held 2 cycles → count = 0, cmd_ready = 0 during reset, then 1; busy/done/wrap = 0.
- LOAD 13, then UP 5 → after load: count = 13 with done. Then count 14, 15, 0 (wrap = 1), 1, 2. done with count = 2; busy high 5 cycles.
- From count 1, DOWN 3 → count 0, 15 (wrap = 1), 14. done with 14.
- From 0, UP 4 with pause high for 2 cycles after the second step → count 0, 1, 2, 2, 2, 3, 4. done with 4; busy 6 cycles; no done while paused.
- UP 0 → done next cycle, count unchanged, busy never high. Then cmd_valid held high with DOWN 2 during RUN of a prior UP 3 → second command accepted only in the cycle done is high.
- From 0, UP 10, reset asserted after 3 steps → count = 0 after that edge. No done; cmd_ready = 1 next cycle; a new LOAD 7 is accepted normally.
